// File: rtl/wb_cmd_master_pkg.sv
// Shared types and header field layout for the TURF command-stream Wishbone initiator.
// The BACKOFF state exists only when WB_CMD_MASTER_RETRY_EN is defined.
package wb_cmd_master_pkg;

    localparam int WE_BIT  = 31;
    localparam int SEL_LSB = 16;
    localparam int SEL_W   = 4;
    localparam int ADR_W   = 12;
    localparam int DAT_W   = 32;

`ifdef WB_CMD_MASTER_RETRY_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WDATA   = 3'd1,
        ST_BUS     = 3'd2,
        ST_RSP     = 3'd3,
        ST_BACKOFF = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WDATA = 3'd1,
        ST_BUS   = 3'd2,
        ST_RSP   = 3'd3
    } state_e;
`endif

    typedef enum logic [1:0] {
        RSP_OK      = 2'b00,
        RSP_WBERR   = 2'b01,
        RSP_TIMEOUT = 2'b10,
        RSP_RETRY   = 2'b11
    } rsp_err_e;

endpackage

// File: rtl/wb_cmd_master.sv
// Turns header(+data) command words into single Wishbone cycles and returns one response word each.
// Optional macro WB_CMD_MASTER_RETRY_EN: reissue the cycle on wb_rty_i up to MAX_RETRY times.
//
// Handshakes: a word moves on cmd_* (or rsp_*) at a rising edge where valid && ready are both high;
// valid, once raised, holds its data stable until that edge.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_WORD       = 32'hDEADBEEF,
    parameter int          MAX_RETRY      = 3
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [DAT_W-1:0] cmd_dat_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    output logic [DAT_W-1:0] rsp_dat_o,
    output logic [1:0]       rsp_err_o,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [ADR_W-1:0] wb_adr_o,
    output logic [DAT_W-1:0] wb_dat_o,
    output logic [SEL_W-1:0] wb_sel_o,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    input  logic             wb_rty_i,
    input  logic [DAT_W-1:0] wb_dat_i,
    output logic [2:0]       dbg_state
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 || MAX_RETRY < 0 || MAX_RETRY > 255) begin : g_bad_param
        $error("wb_cmd_master: parameter out of range");
    end

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] to_cnt_q;
    logic        hdr_acc, dat_acc, term;
    rsp_err_e    term_code;
    logic        cmd_hs;

`ifdef WB_CMD_MASTER_RETRY_EN
    logic [7:0]  retry_cnt_q;
    logic        retry_go;
`endif

    assign cmd_hs    = cmd_valid_i && cmd_ready_o;
    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        hdr_acc   = 1'b0;
        dat_acc   = 1'b0;
        term      = 1'b0;
        term_code = RSP_OK;
`ifdef WB_CMD_MASTER_RETRY_EN
        retry_go  = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    hdr_acc = 1'b1;
                    state_d = cmd_dat_i[WE_BIT] ? ST_WDATA : ST_BUS;
                end
            end
            ST_WDATA: begin
                if (cmd_hs) begin
                    dat_acc = 1'b1;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // Termination priority: err > rty > ack > timeout
                if (wb_err_i) begin
                    term      = 1'b1;
                    term_code = RSP_WBERR;
                end else if (wb_rty_i) begin
`ifdef WB_CMD_MASTER_RETRY_EN
                    if (retry_cnt_q < MAX_RETRY[7:0]) begin
                        retry_go = 1'b1;
                    end else begin
                        term      = 1'b1;
                        term_code = RSP_RETRY;
                    end
`else
                    term      = 1'b1;
                    term_code = RSP_RETRY;
`endif
                end else if (wb_ack_i) begin
                    term = 1'b1;
                end else if (to_cnt_q == TO_LAST) begin
                    term      = 1'b1;
                    term_code = RSP_TIMEOUT;
                end
                if (term) state_d = ST_RSP;
`ifdef WB_CMD_MASTER_RETRY_EN
                if (retry_go) state_d = ST_BACKOFF;
`endif
            end
`ifdef WB_CMD_MASTER_RETRY_EN
            ST_BACKOFF: state_d = ST_BUS;
`endif
            ST_RSP: begin
                if (rsp_valid_o && rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // All outputs are registered off the next state so they line up with the state register.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            cmd_ready_o <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= '0;
            wb_sel_o    <= '0;
            wb_dat_o    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= RSP_OK;
            to_cnt_q    <= '0;
        end else begin
            cmd_ready_o <= (state_d == ST_IDLE) || (state_d == ST_WDATA);
            wb_cyc_o    <= (state_d == ST_BUS);
            wb_stb_o    <= (state_d == ST_BUS);
            rsp_valid_o <= (state_d == ST_RSP);
            // Restarts on every stb rise, including a reissue after backoff
            to_cnt_q    <= (state_q == ST_BUS && state_d == ST_BUS) ? to_cnt_q + 16'd1 : 16'd0;
            if (hdr_acc) begin
                wb_we_o  <= cmd_dat_i[WE_BIT];
                wb_sel_o <= cmd_dat_i[SEL_LSB +: SEL_W];
                wb_adr_o <= cmd_dat_i[ADR_W-1:0];
                wb_dat_o <= '0;
            end
            if (dat_acc) wb_dat_o <= cmd_dat_i;
            if (term) begin
                rsp_err_o <= term_code;
                if (term_code != RSP_OK) rsp_dat_o <= ERR_WORD;
                else if (wb_we_o)        rsp_dat_o <= {{(DAT_W-ADR_W){1'b0}}, wb_adr_o};
                else                     rsp_dat_o <= wb_dat_i;
            end
        end
    end

`ifdef WB_CMD_MASTER_RETRY_EN
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i)     retry_cnt_q <= '0;
        else if (hdr_acc)  retry_cnt_q <= '0;
        else if (retry_go) retry_cnt_q <= retry_cnt_q + 8'd1;
    end
`endif

endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized bench for wb_cmd_master: a transaction-level model predicts each response word,
// error code and stb pulse lengths from the target behaviour chosen for that transaction.
module tb_wb_cmd_master;
  import wb_cmd_master_pkg::*;

  localparam int          T    = 8;
  localparam int          MR   = 3;
  localparam logic [31:0] ERRW = 32'hDEADBEEF;
`ifdef WB_CMD_MASTER_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic        clk, rst_n;
  logic [31:0] cmd_dat_i;
  logic        cmd_valid_i, cmd_ready_o;
  logic [31:0] rsp_dat_o;
  logic [1:0]  rsp_err_o;
  logic        rsp_valid_o, rsp_ready_i;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [11:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i, wb_err_i, wb_rty_i;
  logic [31:0] wb_dat_i;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  exp_err_q[$];

  wb_cmd_master #(.TIMEOUT_CYCLES(T), .ERR_WORD(ERRW), .MAX_RETRY(MR)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .cmd_dat_i(cmd_dat_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .wb_dat_i(wb_dat_i),
    .dbg_state(dbg_state)
  );

  // clock / reset / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver: present one command word and hold it until accepted
  task automatic send_word(input logic [31:0] w);
    int n = 0;
    cmd_dat_i   = w;
    cmd_valid_i = 1'b1;
    while (!cmd_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", {31'b0, cmd_ready_o}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  // target side of one Wishbone attempt: wait for stb, terminate after `delay` wait cycles
  task automatic bus_attempt(input logic we, input logic [3:0] sel, input logic [11:0] adr,
                             input logic [31:0] dat, input int delay,
                             input logic t_ack, input logic t_err, input logic t_rty,
                             output int gap, output int hi);
    logic ok = 1'b1;
    gap = 0;
    hi  = 0;
    while (!wb_stb_o && gap < 8) begin
      @(negedge clk);
      gap++;
    end
    while (wb_stb_o && hi < 4 * T) begin
      hi++;
      if (wb_cyc_o !== 1'b1 || wb_adr_o !== adr || wb_sel_o !== sel || wb_we_o !== we ||
          (we && wb_dat_o !== dat)) ok = 1'b0;
      if (hi == delay + 1) begin
        wb_ack_i = t_ack;
        wb_err_i = t_err;
        wb_rty_i = t_rty;
      end
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_rty_i = 1'b0;
    end
    check("bus_fields", {31'b0, ok}, 32'd1);
    check("cyc_low_after", {31'b0, wb_cyc_o}, 32'd0);
  endtask

  // kind: 0 ack, 1 err, 2 err+ack. nrty: rty terminations before the final one. delay >= T: silent target.
  task automatic run_txn(input logic we, input logic [3:0] sel, input logic [11:0] adr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int delay,
                         input int kind, input int nrty, input int hold);
    int n_att, exp_hi, gap, hi;
    logic [31:0] ew, hdr;
    logic [1:0]  ee;
    logic        ok, is_rty;

    // reference model
    exp_hi = (delay >= T) ? T : delay + 1;
    if (delay >= T) begin
      n_att = 1; ew = ERRW; ee = 2'b10;
    end else if (nrty > 0 && (!RETRY || nrty > MR)) begin
      n_att = RETRY ? MR + 1 : 1; ew = ERRW; ee = 2'b11;
    end else begin
      n_att = nrty + 1;
      if (kind == 0) begin
        ee = 2'b00;
        ew = we ? {20'h0, adr} : rdata;
      end else begin
        ee = 2'b01;
        ew = ERRW;
      end
    end
    exp_q.push_back(ew);
    exp_err_q.push_back(ee);

    hdr = $urandom;
    hdr[31] = we;
    hdr[19:16] = sel;
    hdr[11:0] = adr;
    wb_dat_i = rdata;
    send_word(hdr);
    if (we) send_word(wdata);

    for (int a = 0; a < n_att; a++) begin
      is_rty = (a < nrty);
      if (delay >= T)
        bus_attempt(we, sel, adr, wdata, delay, 1'b0, 1'b0, 1'b0, gap, hi);
      else if (is_rty)
        bus_attempt(we, sel, adr, wdata, delay, 1'($urandom_range(0, 1)), 1'b0, 1'b1, gap, hi);
      else
        bus_attempt(we, sel, adr, wdata, delay, kind != 1, kind != 0, 1'b0, gap, hi);
      check("stb_gap", gap, (a == 0) ? 32'd0 : 32'd1);
      check("stb_cycles", hi, exp_hi);
    end

    // scoreboard
    check("rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
    check("cmd_ready_busy", {31'b0, cmd_ready_o}, 32'd0);
    ew = exp_q.pop_front();
    ee = exp_err_q.pop_front();
    check("rsp_dat", rsp_dat_o, ew);
    check("rsp_err", {30'b0, rsp_err_o}, {30'b0, ee});
    ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid_o !== 1'b1 || rsp_dat_o !== ew || rsp_err_o !== ee ||
          cmd_ready_o !== 1'b0 || wb_stb_o !== 1'b0) ok = 1'b0;
    end
    if (hold > 0) check("rsp_hold", {31'b0, ok}, 32'd1);
    rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready_i = 1'b0;
    check("rsp_drop", {31'b0, rsp_valid_o}, 32'd0);
    check("cmd_ready_back", {31'b0, cmd_ready_o}, 32'd1);
  endtask

  initial begin
    logic ok;
    rst_n = 1'b0;
    cmd_dat_i = '0; cmd_valid_i = 1'b0; rsp_ready_i = 1'b0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {cmd_ready_o, wb_cyc_o, wb_stb_o, rsp_valid_o, rsp_err_o}, 32'd0);
    check("rst_rsp_dat", rsp_dat_o, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", {31'b0, cmd_ready_o}, 32'd1);

    // directed
    run_txn(1'b0, 4'hF, 12'h123, 32'h0, 32'h1234_5678, 2, 0, 0, 0);
    run_txn(1'b1, 4'h3, 12'h040, 32'hCAFE_F00D, 32'h0, 0, 0, 0, 0);
    run_txn(1'b0, 4'h1, 12'h7AA, 32'h0, 32'h5555_AAAA, T, 0, 0, 0);
    run_txn(1'b0, 4'hC, 12'h3C3, 32'h0, 32'h0BAD_0BAD, 1, 2, 0, 5);
    run_txn(1'b1, 4'h5, 12'hFFF, 32'h1357_9BDF, 32'h0, 3, 1, 0, 2);
    run_txn(1'b0, 4'h2, 12'h001, 32'h0, 32'hA5A5_5A5A, T - 1, 0, 0, 1);
    run_txn(1'b0, 4'h6, 12'h222, 32'h0, 32'h0F0F_F0F0, 0, 0, 2, 0);
    run_txn(1'b1, 4'h9, 12'h444, 32'h2468_ACE0, 32'h0, 1, 0, 4, 0);
    run_txn(1'b0, 4'hA, 12'h555, 32'h0, 32'h1111_2222, 0, 0, 1, 0);

    // reset in the middle of a bus cycle
    cmd_dat_i = 32'h000F_0ABC;
    cmd_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    @(negedge clk);
    check("stb_before_rst", {31'b0, wb_stb_o}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_bus", {cmd_ready_o, wb_cyc_o, wb_stb_o, rsp_valid_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst2", {31'b0, cmd_ready_o}, 32'd1);
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid_o !== 1'b0 || wb_stb_o !== 1'b0) ok = 1'b0;
    end
    check("no_rsp_after_rst", {31'b0, ok}, 32'd1);

    // random
    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom_range(0, 1)), 4'($urandom), 12'($urandom), $urandom, $urandom,
              $urandom_range(0, T), $urandom_range(0, 2),
              ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0, $urandom_range(0, 3));
    end

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
